// File: rtl/geometry_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : geometry_sequencer_if
//  Description : Transform-unit channel between the geometry sequencer and
//                the shared camera-transform datapath.
//                  req_valid/req_ready : request handshake
//                  req_vtx             : object-space vertex {z,y,x}
//                  req_model           : model index tagging the request
//                  resp_valid/resp_data: in-order screen-space results,
//                                        no backpressure
//                master = sequencer side, slave = transform-unit side.
//  Revision    : 1.0 - initial release
// ============================================================================
interface geometry_sequencer_if #(
    parameter int MODEL_W = 4,
    parameter int COORD_W = 32
);
    logic                   req_valid;
    logic                   req_ready;
    logic [3*COORD_W-1:0]   req_vtx;
    logic [MODEL_W-1:0]     req_model;
    logic                   resp_valid;
    logic [3*COORD_W-1:0]   resp_data;

    modport master (
        output req_valid, req_vtx, req_model,
        input  req_ready, resp_valid, resp_data
    );

    modport slave (
        input  req_valid, req_vtx, req_model,
        output req_ready, resp_valid, resp_data
    );
endinterface
`default_nettype wire

// File: rtl/geometry_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : geometry_sequencer
//  Description : Walks the model descriptor table on start, fetches every
//                vertex of every triangle, issues it to the transform unit
//                (credit-limited to MAX_OUT in flight) and writes each
//                returned result into the model's render-cache region.
//  Ports       : clk, rst_n (sync, active-low)
//                start/num_models/busy/done/err : control and status
//                desc_*  : descriptor table read (1-cycle latency)
//                vtx_*   : vertex memory read (1-cycle latency)
//                xf      : transform request/response channel (master)
//                rc_*    : render-cache write port
//  Revision    : 1.0 - initial release
// ============================================================================
module geometry_sequencer #(
    parameter int MODEL_W = 4,
    parameter int ADDR_W  = 16,
    parameter int COORD_W = 32,
    parameter int MAX_OUT = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [MODEL_W:0]        num_models,
    output logic                    busy,
    output logic                    done,
    output logic                    err,
    output logic                    desc_rd,
    output logic [MODEL_W-1:0]      desc_addr,
    input  logic [ADDR_W-1:0]       desc_vbase,
    input  logic [ADDR_W-1:0]       desc_ntri,
    input  logic [ADDR_W-1:0]       desc_cbase,
    output logic                    vtx_rd,
    output logic [ADDR_W-1:0]       vtx_addr,
    input  logic [3*COORD_W-1:0]    vtx_data,
    geometry_sequencer_if.master    xf,
    output logic                    rc_we,
    output logic [ADDR_W-1:0]       rc_addr,
    output logic [3*COORD_W-1:0]    rc_data
);
    localparam int         VCNT_W    = ADDR_W + 2;
    localparam logic [3:0] C_MAX_OUT = 4'(MAX_OUT);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_DESC  = 3'd1,
        S_DLAT  = 3'd2,
        S_FETCH = 3'd3,
        S_CAPT  = 3'd4,
        S_ISSUE = 3'd5,
        S_DRAIN = 3'd6,
        S_DONE  = 3'd7
    } state_t;

    state_t                 state_q, state_d;
    logic [MODEL_W-1:0]     m_q, m_d;
    logic [MODEL_W:0]       nm_q, nm_d;
    logic [ADDR_W-1:0]      vbase_q, vbase_d;
    logic [ADDR_W-1:0]      cbase_q, cbase_d;
    logic [VCNT_W-1:0]      vcnt_q, vcnt_d;
    logic [VCNT_W-1:0]      k_q, k_d;
    logic [ADDR_W-1:0]      w_q, w_d;
    logic [3:0]             outst_q, outst_d;
    logic [3*COORD_W-1:0]   hold_q, hold_d;
    logic                   err_q, err_d;

    logic                   req_fire;
    logic                   resp_ok;
    logic                   resp_spur;

    assign busy      = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done      = (state_q == S_DONE);
    assign err       = err_q;
    // Responses only count while a walk is active; one arriving with nothing
    // outstanding is a protocol violation and is flagged instead of written.
    assign resp_ok   = busy && xf.resp_valid && (outst_q != 4'd0);
    assign resp_spur = busy && xf.resp_valid && (outst_q == 4'd0);

    always_comb begin
        state_d      = state_q;
        m_d          = m_q;
        nm_d         = nm_q;
        vbase_d      = vbase_q;
        cbase_d      = cbase_q;
        vcnt_d       = vcnt_q;
        k_d          = k_q;
        w_d          = w_q;
        hold_d       = hold_q;
        err_d        = err_q;
        req_fire     = 1'b0;
        desc_rd      = 1'b0;
        desc_addr    = '0;
        vtx_rd       = 1'b0;
        vtx_addr     = '0;
        xf.req_valid = 1'b0;
        xf.req_vtx   = '0;
        xf.req_model = '0;
        rc_we        = 1'b0;
        rc_addr      = '0;
        rc_data      = '0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    nm_d    = num_models;
                    m_d     = '0;
                    err_d   = 1'b0;
                    state_d = (num_models == '0) ? S_DONE : S_DESC;
                end
            end
            S_DESC: begin
                desc_rd   = 1'b1;
                desc_addr = m_q;
                state_d   = S_DLAT;
            end
            S_DLAT: begin
                vbase_d = desc_vbase;
                cbase_d = desc_cbase;
                // 3*ntri as (ntri + 2*ntri), widened so it cannot overflow
                vcnt_d  = {2'b00, desc_ntri} + {1'b0, desc_ntri, 1'b0};
                k_d     = '0;
                w_d     = '0;
                state_d = (desc_ntri == '0) ? S_DRAIN : S_FETCH;
            end
            S_FETCH: begin
                // Credit gate: this is the only place that bounds outstanding
                if (outst_q < C_MAX_OUT) begin
                    vtx_rd   = 1'b1;
                    vtx_addr = vbase_q + k_q[ADDR_W-1:0];
                    state_d  = S_CAPT;
                end
            end
            S_CAPT: begin
                hold_d  = vtx_data;
                state_d = S_ISSUE;
            end
            S_ISSUE: begin
                xf.req_valid = 1'b1;
                xf.req_vtx   = hold_q;
                xf.req_model = m_q;
                if (xf.req_ready) begin
                    req_fire = 1'b1;
                    k_d      = k_q + VCNT_W'(1);
                    state_d  = (k_q + VCNT_W'(1) == vcnt_q) ? S_DRAIN : S_FETCH;
                end
            end
            S_DRAIN: begin
                if (outst_q == 4'd0) begin
                    if (({1'b0, m_q} + (MODEL_W+1)'(1)) == nm_q) begin
                        state_d = S_DONE;
                    end else begin
                        m_d     = m_q + MODEL_W'(1);
                        state_d = S_DESC;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Response path runs alongside the walk; the write is combinational.
        // The cache write is suppressed while reset is being applied.
        if (resp_ok && rst_n) begin
            rc_we   = 1'b1;
            rc_addr = cbase_q + w_q;
            rc_data = xf.resp_data;
        end
        if (resp_ok) begin
            w_d = w_q + ADDR_W'(1);
        end
        if (resp_spur) begin
            err_d = 1'b1;
        end
        outst_d = outst_q + {3'b000, req_fire} - {3'b000, resp_ok};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            m_q     <= '0;
            nm_q    <= '0;
            vbase_q <= '0;
            cbase_q <= '0;
            vcnt_q  <= '0;
            k_q     <= '0;
            w_q     <= '0;
            outst_q <= '0;
            hold_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            nm_q    <= nm_d;
            vbase_q <= vbase_d;
            cbase_q <= cbase_d;
            vcnt_q  <= vcnt_d;
            k_q     <= k_d;
            w_q     <= w_d;
            outst_q <= outst_d;
            hold_q  <= hold_d;
            err_q   <= err_d;
        end
    end
endmodule
`default_nettype wire
